// File: rtl/lab3_mem_mem_port_arbiter.sv
// Two-requester round-robin arbiter for a single cache-to-memory port.
// Requester 0 is the icache and requester 1 is the dcache. Only one memory
// transaction is in flight at a time. The granted request and the returned
// response are both buffered, and the response goes back to the owner.
module lab3_mem_mem_port_arbiter #(
    parameter int p_req_nbits  = 175,
    parameter int p_resp_nbits = 145,
    parameter int p_cnt_nbits  = 16
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic                    req0_val,
    output logic                    req0_rdy,
    input  logic [p_req_nbits-1:0]  req0_msg,
    output logic                    resp0_val,
    input  logic                    resp0_rdy,
    output logic [p_resp_nbits-1:0] resp0_msg,

    input  logic                    req1_val,
    output logic                    req1_rdy,
    input  logic [p_req_nbits-1:0]  req1_msg,
    output logic                    resp1_val,
    input  logic                    resp1_rdy,
    output logic [p_resp_nbits-1:0] resp1_msg,

    output logic                    memreq_val,
    input  logic                    memreq_rdy,
    output logic [p_req_nbits-1:0]  memreq_msg,
    input  logic                    memresp_val,
    output logic                    memresp_rdy,
    input  logic [p_resp_nbits-1:0] memresp_msg,

    output logic                    grant_id,
    output logic                    busy,
    output logic [p_cnt_nbits-1:0]  count0,
    output logic [p_cnt_nbits-1:0]  count1
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEND = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] RESP = 2'd3;

    localparam logic [p_cnt_nbits-1:0] CNT_ONE = p_cnt_nbits'(1);

    logic [1:0]              state_q, state_d;
    logic                    last_grant_q, last_grant_d;
    logic                    grant_q, grant_d;
    logic [p_req_nbits-1:0]  req_q, req_d;
    logic [p_resp_nbits-1:0] resp_q, resp_d;
    logic [p_cnt_nbits-1:0]  cnt0_q, cnt0_d;
    logic [p_cnt_nbits-1:0]  cnt1_q, cnt1_d;

    logic any_val;
    logic winner;
    logic owner_resp_rdy;

    // Round-robin pick. On a tie, the requester that did not win last time goes first.
    always_comb begin
        any_val        = req0_val | req1_val;
        winner         = (req0_val & req1_val) ? ~last_grant_q : req1_val;
        owner_resp_rdy = grant_q ? resp1_rdy : resp0_rdy;
    end

    // The state is already IDLE while reset is held. The request readies are also
    // gated by reset so that no handshake is offered during reset.
    assign req0_rdy    = ~reset & (state_q == IDLE) & any_val & ~winner;
    assign req1_rdy    = ~reset & (state_q == IDLE) & any_val &  winner;

    assign memreq_val  = (state_q == SEND);
    assign memreq_msg  = req_q;
    assign memresp_rdy = (state_q == WAIT);

    assign resp0_val   = (state_q == RESP) & ~grant_q;
    assign resp1_val   = (state_q == RESP) &  grant_q;
    assign resp0_msg   = resp_q;
    assign resp1_msg   = resp_q;

    assign grant_id    = grant_q;
    assign busy        = (state_q != IDLE);
    assign count0      = cnt0_q;
    assign count1      = cnt1_q;

    // Next-state logic: accept, issue, wait for memory, deliver, then return to IDLE.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        req_d        = req_q;
        resp_d       = resp_q;
        cnt0_d       = cnt0_q;
        cnt1_d       = cnt1_q;
        case (state_q)
            IDLE: begin
                // The winner's rdy equals any_val, so any valid request is a handshake.
                if (any_val) begin
                    req_d        = winner ? req1_msg : req0_msg;
                    grant_d      = winner;
                    last_grant_d = winner;
                    state_d      = SEND;
                end
            end
            SEND: begin
                if (memreq_rdy) state_d = WAIT;
            end
            WAIT: begin
                if (memresp_val) begin
                    resp_d  = memresp_msg;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (owner_resp_rdy) begin
                    if (grant_q) cnt1_d = cnt1_q + CNT_ONE;
                    else         cnt0_d = cnt0_q + CNT_ONE;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers. The reset is asynchronous, and it abandons any transaction in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            req_q        <= '0;
            resp_q       <= '0;
            cnt0_q       <= '0;
            cnt1_q       <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            req_q        <= req_d;
            resp_q       <= resp_d;
            cnt0_q       <= cnt0_d;
            cnt1_q       <= cnt1_d;
        end
    end

endmodule

// File: doc/lab3_mem_mem_port_arbiter.md
Name: lab3_mem_mem_port_arbiter

Overview:
- Shares one cache-to-memory port between two blocking caches (requester 0 = icache, requester 1 = dcache).
- Round-robin arbitration; one outstanding memory transaction at a time.
- Buffers the granted request and the returned response, and routes the response back to the granted requester.
- Sits between the two cache2mem interfaces and the test memory / main memory port.

Parameters:
- p_req_nbits, 175, width of memory request message; contents opaque to this block.
- p_resp_nbits, 145, width of memory response message; contents opaque to this block.
- p_cnt_nbits, 16, width of per-requester completed-transaction counters.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- req0_val  input  1  requester 0 request valid.
- req0_rdy  output  1  requester 0 request ready.
- req0_msg  input  p_req_nbits  requester 0 request.
- resp0_val  output  1  response valid to requester 0.
- resp0_rdy  input  1  requester 0 response ready.
- resp0_msg  output  p_resp_nbits  response to requester 0.
- req1_val / req1_rdy / req1_msg, resp1_val / resp1_rdy / resp1_msg: same as requester 0, for requester 1.
- memreq_val  output  1  memory request valid.
- memreq_rdy  input  1  memory request ready.
- memreq_msg  output  p_req_nbits  memory request.
- memresp_val  input  1  memory response valid.
- memresp_rdy  output  1  memory response ready.
- memresp_msg  input  p_resp_nbits  memory response.
- grant_id  output  1  requester owning the current transaction.
- busy  output  1  high in any state other than IDLE.
- count0  output  p_cnt_nbits  completed transactions, requester 0.
- count1  output  p_cnt_nbits  completed transactions, requester 1.

Behaviour:
- Clock and reset: one clock `clk`; reset is asynchronous and active-high (`reset`). All state registers clear immediately on reset assertion.
- Reset values:
  - state = IDLE; last_grant = 1, so requester 0 wins the first tie; grant_id = 0.
  - req_reg = 0, resp_reg = 0, count0 = count1 = 0.
  - All val/rdy outputs = 0 while reset is high.
- Arbitration (combinational, evaluated only in IDLE):
  - If exactly one reqN_val is high, that requester wins.
  - If both are high, winner = !last_grant.
  - reqN_rdy = 1 only for the winner and only in IDLE. The loser's rdy is 0.
- FSM, 4 states:
  - IDLE: on a winner handshake (val && rdy), capture req_reg <= winner msg, grant_id <= winner, last_grant <= winner, go to SEND. Otherwise stay.
  - SEND: memreq_val = 1, memreq_msg = req_reg. On memreq_rdy go to WAIT; otherwise hold, with msg stable.
  - WAIT: memresp_rdy = 1. On memresp_val capture resp_reg <= memresp_msg and go to RESP.
  - RESP: resp{grant_id}_val = 1; the other resp_val = 0. On resp{grant_id}_rdy, increment count{grant_id} and go to IDLE.
- Output defaults:
  - memreq_msg is always driven from req_reg.
  - resp0_msg and resp1_msg are both always driven from resp_reg; only val qualifies them.
  - memresp_rdy = 0 outside WAIT, so responses arriving in any other state are not accepted.
- Latency: request accepted in cycle t; memreq_val in t+1; earliest memresp accept t+2; resp_val at t+3. Minimum 4 cycles per transaction.
- A new request cannot be accepted in the same cycle a response handshake completes. IDLE is always re-entered first.
- Counters wrap from all-ones to 0 with no saturation.
- Request valid deassertion: a requester may drop val while not granted, with no effect.
- Reset mid-operation: the in-flight transaction is abandoned, and no response is delivered for it. Any late memresp is ignored because memresp_rdy is only high in WAIT.

Test Plan:
- Single request from req0 (msg 0x..A5), memory responds in the same cycle it sees memresp_rdy → memreq_msg = 0x..A5 at t+1, resp0_val at t+3 with the memory msg, resp1_val stays 0, count0 = 1.
- Both valid continuously for 4 transactions from reset → grant order 0,1,0,1; count0 = count1 = 2; loser's rdy = 0 every IDLE cycle.
- memreq_rdy held low 5 cycles, then memresp delayed 7 cycles → state holds in SEND/WAIT, memreq_msg stable, no resp_val until after capture, busy high throughout.
- resp1_rdy low 3 cycles in RESP → resp1_val and resp1_msg held; no new req accepted; transition to IDLE on the cycle rdy rises.
- Assert reset asynchronously during WAIT, then send memresp_val → memresp_rdy = 0, state = IDLE, counters 0, no resp_val; the next req0 proceeds normally.
- Force count0 to all-ones via 2^p_cnt_nbits transactions (p_cnt_nbits = 4 override, 16 transactions) → count0 wraps to 0.
